// File: rtl/icache_intc_req_arb_rr.sv
// Round-robin fetch-request arbiter merging N_CORES ports onto one cache-bank port.
// Define ICACHE_INTC_REQ_ARB_OUT_REG_EN to insert a one-entry registered output slice.
module icache_intc_req_arb_rr #(
    parameter  int unsigned N_CORES       = 16,
    parameter  int unsigned ADDRESS_WIDTH = 32,
    parameter  int unsigned UID_WIDTH     = 20,
    localparam int unsigned IDX_W         = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [N_CORES-1:0]                 request_i,
    input  logic [N_CORES*ADDRESS_WIDTH-1:0]   address_i,
    input  logic [N_CORES*UID_WIDTH-1:0]       UID_i,
    output logic [N_CORES-1:0]                 grant_o,
    output logic                               request_o,
    output logic [ADDRESS_WIDTH-1:0]           address_o,
    output logic [UID_WIDTH-1:0]               UID_o,
    output logic [IDX_W-1:0]                   port_id_o,
    input  logic                               grant_i
);

    localparam int unsigned CW = IDX_W + 1;

    logic [IDX_W-1:0]         rr_ptr_q;
    logic [IDX_W-1:0]         win_idx;
    logic [IDX_W-1:0]         ptr_nxt;
    logic                     win_valid;
    logic                     req_any;
    logic                     up_grant;
    logic [ADDRESS_WIDTH-1:0] win_addr;
    logic [UID_WIDTH-1:0]     win_uid;

    logic [ADDRESS_WIDTH-1:0] addr_arr [N_CORES];
    logic [UID_WIDTH-1:0]     uid_arr  [N_CORES];

    for (genvar g = 0; g < N_CORES; g++) begin : g_unpack
        assign addr_arr[g] = address_i[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign uid_arr[g]  = UID_i[g*UID_WIDTH +: UID_WIDTH];
    end

    // Scan upward from rr_ptr, wrapping at N_CORES-1; first requester wins.
    always_comb begin
        logic [CW-1:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < N_CORES; off++) begin
            cand = {1'b0, rr_ptr_q} + CW'(off);
            if (cand >= CW'(N_CORES)) begin
                cand = cand - CW'(N_CORES);
            end
            if (!win_valid && request_i[cand[IDX_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign win_addr = addr_arr[win_idx];
    assign win_uid  = uid_arr[win_idx];
    assign ptr_nxt  = (win_idx == IDX_W'(N_CORES - 1)) ? '0 : win_idx + 1'b1;

    // Gating with rst_ni keeps every output, including grants, at zero during reset.
    assign req_any = win_valid & rst_ni;

    always_comb begin
        grant_o = '0;
        if (up_grant) begin
            grant_o[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (up_grant) begin
            rr_ptr_q <= ptr_nxt;
        end
    end

`ifdef ICACHE_INTC_REQ_ARB_OUT_REG_EN

    logic                     valid_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [UID_WIDTH-1:0]     uid_q;
    logic [IDX_W-1:0]         id_q;

    assign up_grant = req_any & (!valid_q | grant_i);

    // A drained slot with nothing to load is zeroed so idle outputs read as 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            uid_q   <= '0;
            id_q    <= '0;
        end else if (up_grant) begin
            valid_q <= 1'b1;
            addr_q  <= win_addr;
            uid_q   <= win_uid;
            id_q    <= win_idx;
        end else if (grant_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            uid_q   <= '0;
            id_q    <= '0;
        end
    end

    assign request_o = valid_q;
    assign address_o = addr_q;
    assign UID_o     = uid_q;
    assign port_id_o = id_q;

`else

    assign up_grant  = req_any & grant_i;
    assign request_o = req_any;
    assign address_o = req_any ? win_addr : '0;
    assign UID_o     = req_any ? win_uid  : '0;
    assign port_id_o = req_any ? win_idx  : '0;

`endif

endmodule

// File: tb/tb_icache_intc_req_arb_rr.sv
// Directed self-checking bench for icache_intc_req_arb_rr (N_CORES = 7, both build modes).
module tb_icache_intc_req_arb_rr;

    localparam int unsigned N  = 7;
    localparam int unsigned AW = 32;
    localparam int unsigned UW = 20;

    logic              clk_i;
    logic              rst_ni;
    logic [N-1:0]      request_i;
    logic [N*AW-1:0]   address_i;
    logic [N*UW-1:0]   UID_i;
    logic [N-1:0]      grant_o;
    logic              request_o;
    logic [AW-1:0]     address_o;
    logic [UW-1:0]     UID_o;
    logic [2:0]        port_id_o;
    logic              grant_i;

    int n_cmp;
    int n_err;

    icache_intc_req_arb_rr #(
        .N_CORES      (N),
        .ADDRESS_WIDTH(AW),
        .UID_WIDTH    (UW)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .request_i(request_i),
        .address_i(address_i),
        .UID_i    (UID_i),
        .grant_o  (grant_o),
        .request_o(request_o),
        .address_o(address_o),
        .UID_o    (UID_o),
        .port_id_o(port_id_o),
        .grant_i  (grant_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [AW-1:0] def_addr(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h40;
    endfunction

    function automatic logic [UW-1:0] def_uid(input int i);
        return 20'h00050 + 20'(i);
    endfunction

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic [UW-1:0] u);
        address_i[i*AW +: AW] = a;
        UID_i[i*UW +: UW]     = u;
    endtask

    function automatic logic [63:0] oh(input int i);
        return 64'(1) << i;
    endfunction

    int sp_grant [3] = '{3, 1, 3};
    int sp_reg_id[3] = '{1, 3, 1};

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_ni    = 1'b0;
        grant_i   = 1'b1;
        request_i = 7'h5B;
        address_i = '0;
        UID_i     = '0;
        for (int i = 0; i < N; i++) set_port(i, def_addr(i), def_uid(i));

        // Reset held with live requests
        @(negedge clk_i);
        check_eq("rst_request_o", request_o, 0);
        check_eq("rst_grant_o",   grant_o,   0);
        check_eq("rst_address_o", address_o, 0);
        check_eq("rst_uid_o",     UID_o,     0);
        check_eq("rst_port_id_o", port_id_o, 0);

        // Full rotation, all ports requesting
        step();
        rst_ni    = 1'b1;
        request_i = '1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk_i);
            check_eq("rot_grant", grant_o, oh(k % 7));
`ifdef ICACHE_INTC_REQ_ARB_OUT_REG_EN
            if (k == 0) check_eq("rot_req_first", request_o, 0);
            else        check_eq("rot_port_id", port_id_o, 64'((k - 1) % 7));
`else
            check_eq("rot_port_id", port_id_o, 64'(k % 7));
            check_eq("rot_req",     request_o, 1);
`endif
            step();
        end

        // Sparse wrap from rr_ptr = 2
        request_i = 7'b0001010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_eq("sparse_grant", grant_o, oh(sp_grant[k]));
`ifdef ICACHE_INTC_REQ_ARB_OUT_REG_EN
            check_eq("sparse_port_id", port_id_o, 64'(sp_reg_id[k]));
`else
            check_eq("sparse_port_id", port_id_o, 64'(sp_grant[k]));
`endif
            step();
        end

        // Stall / backpressure with rr_ptr = 4
        request_i = '1;
        grant_i   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_eq("stall_grant", grant_o,   0);
            check_eq("stall_req",   request_o, 1);
`ifdef ICACHE_INTC_REQ_ARB_OUT_REG_EN
            check_eq("stall_port_id", port_id_o, 3);
            check_eq("stall_addr",    address_o, def_addr(3));
            check_eq("stall_uid",     UID_o,     def_uid(3));
`else
            check_eq("stall_port_id", port_id_o, 4);
            check_eq("stall_addr",    address_o, def_addr(4));
`endif
            step();
        end
        grant_i = 1'b1;
        @(negedge clk_i);
        check_eq("resume_grant0", grant_o, oh(4));
`ifdef ICACHE_INTC_REQ_ARB_OUT_REG_EN
        check_eq("resume_id0", port_id_o, 3);
`else
        check_eq("resume_id0", port_id_o, 4);
`endif
        step();
        @(negedge clk_i);
        check_eq("resume_grant1", grant_o, oh(5));
`ifdef ICACHE_INTC_REQ_ARB_OUT_REG_EN
        check_eq("resume_id1", port_id_o, 4);
`else
        check_eq("resume_id1", port_id_o, 5);
`endif
        step();

        // Asynchronous reset mid-operation
        grant_i = 1'b0;
        @(negedge clk_i);
        check_eq("pre_rst_req",   request_o, 1);
        check_eq("pre_rst_grant", grant_o,   0);
`ifdef ICACHE_INTC_REQ_ARB_OUT_REG_EN
        check_eq("pre_rst_id", port_id_o, 5);
`else
        check_eq("pre_rst_id", port_id_o, 6);
`endif
        #1 rst_ni = 1'b0;
        #1;
        check_eq("async_rst_req",   request_o, 0);
        check_eq("async_rst_grant", grant_o,   0);
        check_eq("async_rst_id",    port_id_o, 0);
        check_eq("async_rst_addr",  address_o, 0);
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
`ifdef ICACHE_INTC_REQ_ARB_OUT_REG_EN
        check_eq("post_rst_req",   request_o, 0);
        check_eq("post_rst_grant", grant_o,   oh(0));
`else
        check_eq("post_rst_req",   request_o, 1);
        check_eq("post_rst_id",    port_id_o, 0);
        check_eq("post_rst_grant", grant_o,   0);
`endif
        step();

        // Single requester on port 6
        request_i = 7'h40;
        set_port(6, 32'h1000_0040, 20'h0005A);
        grant_i   = 1'b1;
        @(negedge clk_i);
        check_eq("p6_grant", grant_o, oh(6));
`ifndef ICACHE_INTC_REQ_ARB_OUT_REG_EN
        check_eq("p6_req",  request_o, 1);
        check_eq("p6_addr", address_o, 32'h1000_0040);
        check_eq("p6_uid",  UID_o,     20'h0005A);
        check_eq("p6_id",   port_id_o, 6);
`endif
        step();
        request_i = '0;
        @(negedge clk_i);
`ifdef ICACHE_INTC_REQ_ARB_OUT_REG_EN
        check_eq("p6_req",   request_o, 1);
        check_eq("p6_addr",  address_o, 32'h1000_0040);
        check_eq("p6_uid",   UID_o,     20'h0005A);
        check_eq("p6_id",    port_id_o, 6);
        check_eq("p6_grant_after", grant_o, 0);
`else
        check_eq("idle0_req",   request_o, 0);
        check_eq("idle0_grant", grant_o,   0);
`endif
        step();

        // Idle: nothing requesting
        @(negedge clk_i);
        check_eq("idle_req",   request_o, 0);
        check_eq("idle_addr",  address_o, 0);
        check_eq("idle_uid",   UID_o,     0);
        check_eq("idle_grant", grant_o,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_intc_req_arb_rr.md
# icache_intc_req_arb_rr

Parametrised round-robin request arbiter for the instruction-cache interconnect, successor to the fixed binary-tree request network. It merges N_CORES fetch requests onto one cache-bank port. Unlike the tree, it:
- supports any N_CORES (no power-of-2 padding);
- uses a true last-winner round-robin pointer instead of a free-running flag counter;
- emits the winning port index for response routing;
- optionally adds a registered output slice with valid/grant backpressure.

## Interface
Parameters:
- N_CORES, 16, number of requesting ports (≥1, any integer)
- ADDRESS_WIDTH, 32, fetch address width
- UID_WIDTH, 20, request ID width
- Derived: IDX_W = max(1, $clog2(N_CORES))

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- request_i  in  N_CORES  per-port request
- address_i  in  N_CORES×ADDRESS_WIDTH  per-port address
- UID_i  in  N_CORES×UID_WIDTH  per-port ID
- grant_o  out  N_CORES  per-port grant; at most one-hot
- request_o  out  1  request to bank
- address_o  out  ADDRESS_WIDTH  winning address
- UID_o  out  UID_WIDTH  winning ID
- port_id_o  out  IDX_W  index of winning port
- grant_i  in  1  bank accepts request_o

## Operation
- Winner selection is combinational: the first set bit of request_i at index ≥ rr_ptr, scanning upward and wrapping at N_CORES-1 → 0.
- rr_ptr is an IDX_W register with range 0..N_CORES-1. On every accepted upstream transfer it loads (winner+1), with winner = N_CORES-1 mapping to 0. It never takes values ≥ N_CORES.
- Accepted upstream transfer: grant_o[winner] = 1 while request_i[winner] = 1.
- grant_o is zero when no request is pending. grant_o[i] never asserts unless request_i[i] = 1.
- N_CORES = 1: winner is always 0, port_id_o is 0, and rr_ptr stays 0.
- A requester holds request_i, address_i and UID_i stable until granted. The arbiter may change its winner between cycles only if the current winner is not granted and rr_ptr is unchanged. It never revokes a winner that is still requesting.

## Timing
- Reset values: rr_ptr = 0, and request_o, address_o, UID_o, port_id_o, grant_o = 0. Output register state is cleared.
- Reset is asynchronous. Assertion mid-transfer discards the in-flight request in the output register with no grant side effects. The first cycle after release arbitrates from port 0.
- Pass-through mode (macro absent):
  - Latency is 0.
  - request_o = |request_i.
  - address_o, UID_o and port_id_o come from the winner; all are 0 when request_o = 0.
  - grant_o[winner] = grant_i & request_o, in the same cycle.
  - rr_ptr updates on request_o & grant_i.
- Registered mode is described under Configuration.

## Configuration
- Macro: ICACHE_INTC_REQ_ARB_OUT_REG_EN.
- Defined: a one-entry output register (valid_q plus address/UID/port_id) is inserted between the arbiter and the bank.
  - request_o = valid_q, and the outputs come straight from flops.
  - Upstream grant fires when request_i is non-zero and (!valid_q | grant_i).
  - Latency is 1 cycle.
  - Throughput is one request per cycle when grant_i is held high; a drain and a load in the same cycle are legal.
  - While valid_q & !grant_i, the outputs hold bit-stable and grant_o = 0.
  - rr_ptr updates on upstream grant, not on grant_i.
- Undefined: pass-through mode as described under Timing. No flops other than rr_ptr.

## Test plan
- **Reset:** hold rst_ni = 0 with random inputs → all outputs 0. Release with request_i = all-ones and grant_i = 1 → first grant_o = 0b00001 (port 0), port_id_o = 0.
- **Full rotation, non-power-of-2:** N_CORES = 5, all requesting, grant_i = 1 every cycle → port_id_o sequence 0,1,2,3,4,0,1. Each grant_o is one-hot, and rr_ptr never reaches 5.
- **Sparse wrap:** rr_ptr = 2 and request_i = 0b01010 → grant port 3, then port 1, then port 3 if both are still requesting. Ports 0, 2 and 4 are never granted.
- **Pass-through latency:** macro absent, request_i[6] = 1 alone, address_i[6] = 0x1000_0040, UID_i[6] = 0x5A → same cycle request_o = 1, address_o = 0x1000_0040, UID_o = 0x5A, port_id_o = 6, grant_o[6] = grant_i.
- **Backpressure:** macro defined, all requesting, grant_i = 0 for 3 cycles → request_o = 1 with outputs bit-stable, and grant_o = 0 after the first load. Then grant_i = 1 → the held entry drains and the next winner loads in the same cycle; 1 transfer per cycle thereafter.
- **Reset mid-operation:** macro defined, valid_q = 1 with grant_i = 0, assert rst_ni for 1 cycle → request_o drops to 0 asynchronously with no grant_o pulse. After release, arbitration restarts at port 0.
